// File: rtl/dmem_write_buffer_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : dmem_write_buffer_pkg
//  Description : Shared types and constants for the DMEM write buffer:
//                the controller state encoding and the data-bus width.
//  Revision    : 1.0 - initial release
// ============================================================================
package dmem_write_buffer_pkg;

  localparam int DATA_W = 32;

  // Controller states for the backing-memory bus.
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WR_WAIT = 2'd1,
    RD_WAIT = 2'd2,
    RD_RESP = 2'd3
  } wb_state_t;

endpackage
`default_nettype wire

// File: rtl/dmem_write_buffer_wbuf_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : wbuf_fifo
//  Description : Posted-write storage for the DMEM write buffer.
//                Circular buffer of {word address, data} entries.
//                It provides the head entry and the entry behind it so that
//                writes can be drained back to back. A parallel search
//                returns the youngest entry whose address matches the
//                lookup address.
//  Ports       : clk, rst_n            clock / async active-low reset
//                push, push_addr/data  enqueue at tail (ignored when full)
//                pop                   dequeue head (ignored when empty)
//                full, empty, count    occupancy
//                head_addr/data        oldest entry
//                next_addr/data        entry behind the head
//                lookup_addr           word index to forward
//                hit, hit_data         youngest matching entry
//  Revision    : 1.0 - initial release
// ============================================================================
module wbuf_fifo
  import dmem_write_buffer_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int AW    = 14
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  logic [AW-1:0]          push_addr,
  input  logic [DATA_W-1:0]      push_data,
  input  logic                   pop,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count,
  output logic [AW-1:0]          head_addr,
  output logic [DATA_W-1:0]      head_data,
  output logic [AW-1:0]          next_addr,
  output logic [DATA_W-1:0]      next_data,
  input  logic [AW-1:0]          lookup_addr,
  output logic                   hit,
  output logic [DATA_W-1:0]      hit_data
);

  localparam int PW = $clog2(DEPTH);

  logic [AW-1:0]     addr_q [DEPTH];
  logic [DATA_W-1:0] data_q [DEPTH];
  logic [PW-1:0]     head;
  logic [PW-1:0]     tail;
  logic [PW:0]       cnt;
  logic              do_push;
  logic              do_pop;

  assign full    = (cnt == (PW+1)'(DEPTH));
  assign empty   = (cnt == '0);
  assign count   = cnt;
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head <= '0;
      tail <= '0;
      cnt  <= '0;
    end else begin
      if (do_push) tail <= tail + PW'(1);
      if (do_pop)  head <= head + PW'(1);
      if (do_push && !do_pop)      cnt <= cnt + (PW+1)'(1);
      else if (do_pop && !do_push) cnt <= cnt - (PW+1)'(1);
    end
  end

  // Entry storage needs no reset: the count guards every read.
  always_ff @(posedge clk) begin
    if (do_push) begin
      addr_q[tail] <= push_addr;
      data_q[tail] <= push_data;
    end
  end

  assign head_addr = addr_q[head];
  assign head_data = data_q[head];
  assign next_addr = addr_q[head + PW'(1)];
  assign next_data = data_q[head + PW'(1)];

  // Walk from oldest to youngest; a later match overrides an earlier one,
  // so the result is the most recent store to that word.
  always_comb begin
    hit      = 1'b0;
    hit_data = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (((PW+1)'(i) < cnt) && (addr_q[head + PW'(i)] == lookup_addr)) begin
        hit      = 1'b1;
        hit_data = data_q[head + PW'(i)];
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/dmem_write_buffer.sv
`default_nettype none
// ============================================================================
//  Module      : dmem_write_buffer
//  Description : DMEM front end with posted writes. Stores are queued and
//                drained to a multi-cycle backing memory over a req/ack bus.
//                Loads that hit the queue are forwarded with no added delay.
//                A load that misses holds the CPU with stall while the word
//                is fetched from the backing memory.
//  Ports       : clk, rst_n                          clock / async reset
//                cpu_valid, cpu_read_wrn, cpu_addr,
//                cpu_wdata, cpu_rdata                CPU memory-stage bus
//                stall                               CPU pipeline hold
//                mem_req, mem_we, mem_addr,
//                mem_wdata, mem_rdata, mem_ack       backing-memory bus
//  Revision    : 1.0 - initial release
// ============================================================================
module dmem_write_buffer
  import dmem_write_buffer_pkg::*;
#(
  parameter int BUF_DEPTH = 4,
  parameter int ADDR_W    = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cpu_valid,
  input  logic              cpu_read_wrn,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [31:0]       cpu_wdata,
  output logic [31:0]       cpu_rdata,
  output logic              stall,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-3:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  input  logic              mem_ack
);

  localparam int WA_W = ADDR_W - 2;
  localparam int CW   = $clog2(BUF_DEPTH) + 1;

  wb_state_t         state, state_nxt;
  logic [WA_W-1:0]   cpu_word;
  logic              unused_byte_bits;
  logic              is_load, is_store, push, pop, load_miss;
  logic              full, empty, hit;
  logic [CW-1:0]     fifo_count;
  logic [WA_W-1:0]   head_addr, next_addr;
  logic [31:0]       head_data, next_data, hit_data;
  logic [31:0]       rd_hold;
  logic              req_nxt, we_nxt;
  logic [WA_W-1:0]   addr_nxt;
  logic [31:0]       wdata_nxt;

  assign cpu_word         = cpu_addr[ADDR_W-1:2];
  assign unused_byte_bits = ^cpu_addr[1:0];
  assign is_load          = cpu_valid && cpu_read_wrn;
  assign is_store         = cpu_valid && !cpu_read_wrn;
  assign push             = is_store && !full;
  assign pop              = (state == WR_WAIT) && mem_ack;
  // The load held during RD_RESP is being served from rd_hold, not re-fetched.
  assign load_miss        = is_load && !hit && (state != RD_RESP);

  wbuf_fifo #(
    .DEPTH (BUF_DEPTH),
    .AW    (WA_W)
  ) u_fifo (
    .clk         (clk),
    .rst_n       (rst_n),
    .push        (push),
    .push_addr   (cpu_word),
    .push_data   (cpu_wdata),
    .pop         (pop),
    .full        (full),
    .empty       (empty),
    .count       (fifo_count),
    .head_addr   (head_addr),
    .head_data   (head_data),
    .next_addr   (next_addr),
    .next_data   (next_data),
    .lookup_addr (cpu_word),
    .hit         (hit),
    .hit_data    (hit_data)
  );

  // CPU-facing response: combinational from the current queue and state.
  always_comb begin
    stall     = 1'b0;
    cpu_rdata = '0;
    if (is_store && full) stall = 1'b1;
    if (is_load) begin
      if (state == RD_RESP) cpu_rdata = rd_hold;
      else if (hit)         cpu_rdata = hit_data;
      else                  stall     = 1'b1;
    end
  end

  always_comb begin
    state_nxt = state;
    req_nxt   = mem_req;
    we_nxt    = mem_we;
    addr_nxt  = mem_addr;
    wdata_nxt = mem_wdata;
    case (state)
      IDLE: begin
        if (load_miss) begin
          state_nxt = RD_WAIT;
          req_nxt   = 1'b1;
          we_nxt    = 1'b0;
          addr_nxt  = cpu_word;
        end else if (!empty) begin
          state_nxt = WR_WAIT;
          req_nxt   = 1'b1;
          we_nxt    = 1'b1;
          addr_nxt  = head_addr;
          wdata_nxt = head_data;
        end
      end
      WR_WAIT: begin
        if (mem_ack) begin
          if (load_miss) begin
            state_nxt = RD_WAIT;
            we_nxt    = 1'b0;
            addr_nxt  = cpu_word;
          end else if (fifo_count > CW'(1)) begin
            addr_nxt  = next_addr;
            wdata_nxt = next_data;
          end else if (push) begin
            // Only entry is leaving and a new one arrives this edge:
            // take it straight from the CPU bus.
            addr_nxt  = cpu_word;
            wdata_nxt = cpu_wdata;
          end else begin
            state_nxt = IDLE;
            req_nxt   = 1'b0;
          end
        end
      end
      RD_WAIT: begin
        if (mem_ack) begin
          state_nxt = RD_RESP;
          req_nxt   = 1'b0;
        end
      end
      RD_RESP: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      rd_hold   <= '0;
    end else begin
      state     <= state_nxt;
      mem_req   <= req_nxt;
      mem_we    <= we_nxt;
      mem_addr  <= addr_nxt;
      mem_wdata <= wdata_nxt;
      if (state == RD_WAIT && mem_ack) rd_hold <= mem_rdata;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_dmem_write_buffer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_dmem_write_buffer
//  Description : Self-checking bench for dmem_write_buffer. A behavioural
//                model (program-order memory image plus a queue of accepted,
//                not yet written stores) predicts stall, load data and the
//                backing-bus write sequence. A backing-memory model answers
//                requests with configurable latency.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_dmem_write_buffer;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst_n, cpu_valid, cpu_read_wrn, mem_ack;
  logic [15:0] cpu_addr;
  logic [31:0] cpu_wdata, mem_rdata;
  logic [31:0] cpu_rdata, mem_wdata;
  logic        stall, mem_req, mem_we;
  logic [13:0] mem_addr;

  dmem_write_buffer #(.BUF_DEPTH(DEPTH), .ADDR_W(16)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .cpu_valid    (cpu_valid),
    .cpu_read_wrn (cpu_read_wrn),
    .cpu_addr     (cpu_addr),
    .cpu_wdata    (cpu_wdata),
    .cpu_rdata    (cpu_rdata),
    .stall        (stall),
    .mem_req      (mem_req),
    .mem_we       (mem_we),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_rdata    (mem_rdata),
    .mem_ack      (mem_ack)
  );

  always #5 clk = ~clk;

  typedef struct {logic [13:0] a; logic [31:0] d;} ent_t;

  int          total = 0;
  int          bad   = 0;
  int          rd_cnt = 0;
  int          wr_cnt = 0;
  int          mem_lat = 0;
  bit          rand_lat = 0;
  logic [31:0] bmem    [16384];
  logic [31:0] ref_mem [16384];
  ent_t        pend[$];
  logic [14:0] txn_log[$];
  logic [31:0] wdata_log[$];
  bit          prev_rd_ack = 0;

  bit          m_busy = 0;
  int          m_rem = 0;
  logic        s_we;
  logic [13:0] s_addr;
  logic [31:0] s_wd;

  logic [13:0] mw;
  int          msz;
  bit          mh;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Present one CPU operation (called at posedge+1) and hold it until the
  // DUT stops stalling. Returns the data seen and the number of stall cycles.
  task automatic cpu_op(input logic rd, input logic [15:0] a, input logic [31:0] wd,
                        output logic [31:0] got, output int stalls);
    int rd0;
    rd0          = rd_cnt;
    stalls       = 0;
    cpu_valid    = 1'b1;
    cpu_read_wrn = rd;
    cpu_addr     = a;
    cpu_wdata    = wd;
    @(negedge clk);
    while (stall && stalls < 200) begin
      stalls++;
      @(negedge clk);
    end
    if (stall) begin
      total++;
      bad++;
      $display("FAIL op_timeout actual=stalled required=released addr=%0h", a);
    end
    got = cpu_rdata;
    @(posedge clk);
    #1;
    cpu_valid = 1'b0;
    if (rd) chk("rd_count", 64'(rd_cnt - rd0), (stalls > 0) ? 64'd1 : 64'd0);
  endtask

  // Backing memory: accepts a request, acks it after the chosen latency.
  initial begin
    mem_ack   = 1'b0;
    mem_rdata = '0;
    forever begin
      @(posedge clk);
      #1;
      if (!rst_n) begin
        m_busy  = 0;
        mem_ack = 1'b0;
      end else begin
        if (mem_ack) begin
          mem_ack = 1'b0;
          m_busy  = 0;
        end
        if (m_busy) begin
          chk("bus_hold", {mem_req, mem_we, mem_addr, mem_wdata}, {1'b1, s_we, s_addr, s_wd});
        end else if (mem_req) begin
          m_busy = 1;
          s_we   = mem_we;
          s_addr = mem_addr;
          s_wd   = mem_wdata;
          m_rem  = rand_lat ? int'($urandom_range(0, 3)) : mem_lat;
          txn_log.push_back({mem_we, mem_addr});
          if (mem_we) begin
            wr_cnt++;
            wdata_log.push_back(mem_wdata);
          end else begin
            rd_cnt++;
            chk("rd_req_addr", {cpu_valid, cpu_read_wrn, mem_addr}, {2'b11, cpu_addr[15:2]});
          end
        end
        if (m_busy) begin
          if (m_rem == 0) begin
            mem_ack = 1'b1;
            if (s_we) bmem[s_addr] = s_wd;
            else      mem_rdata = bmem[s_addr];
          end else begin
            m_rem--;
          end
        end
      end
    end
  end

  // Compare process: every cycle, outputs against the behavioural model.
  always @(negedge clk) begin
    if (!rst_n) begin
      pend.delete();
      ref_mem     = bmem;
      prev_rd_ack = 0;
      chk("rst_req", {63'd0, mem_req}, 64'd0);
      chk("rst_stall", {63'd0, stall}, 64'd0);
    end else begin
      mw  = cpu_addr[15:2];
      msz = pend.size();
      mh  = 0;
      foreach (pend[i]) if (pend[i].a == mw) mh = 1;
      if (mem_req && mem_ack && mem_we) begin
        if (msz == 0) begin
          total++;
          bad++;
          $display("FAIL wr_unexpected actual=write@%0h required=none", mem_addr);
        end else begin
          chk("wr_addr", mem_addr, pend[0].a);
          chk("wr_data", mem_wdata, pend[0].d);
          void'(pend.pop_front());
        end
      end
      if (cpu_valid && !cpu_read_wrn) begin
        chk("st_stall", stall, (msz == DEPTH));
        if (!stall) begin
          pend.push_back('{mw, cpu_wdata});
          ref_mem[mw] = cpu_wdata;
        end
      end else if (cpu_valid) begin
        chk("ld_stall", stall, !(mh || prev_rd_ack));
        if (!stall) chk("ld_data", cpu_rdata, ref_mem[mw]);
      end else begin
        chk("idle_out", {stall, cpu_rdata}, 64'd0);
      end
      prev_rd_ack = mem_req && mem_ack && !mem_we;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] got;
    int          st;
    int          wr0;
    for (int i = 0; i < 16384; i++) bmem[i] = 32'h3000_0000 + 32'(i) * 32'h0101;
    ref_mem      = bmem;
    rst_n        = 1'b0;
    cpu_valid    = 1'b0;
    cpu_read_wrn = 1'b0;
    cpu_addr     = '0;
    cpu_wdata    = '0;
    repeat (3) @(negedge clk);
    chk("reset_stall", {63'd0, stall}, 64'd0);
    chk("reset_req", {63'd0, mem_req}, 64'd0);
    chk("reset_we", {63'd0, mem_we}, 64'd0);
    chk("reset_addr", mem_addr, 64'd0);
    chk("reset_wdata", mem_wdata, 64'd0);
    chk("reset_rdata", cpu_rdata, 64'd0);
    @(posedge clk);
    #3 rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Store then immediate load of the same word, backing ack held off.
    mem_lat = 40;
    cpu_op(1'b0, 16'h0010, 32'hDEADBEEF, got, st);
    cpu_op(1'b1, 16'h0010, 32'h0, got, st);
    chk("t1_data", got, 32'hDEADBEEF);
    chk("t1_stall", st, 0);
    idle(50);

    // Two stores to one word: youngest forwarded, both drained in order.
    mem_lat = 2;
    txn_log.delete();
    wdata_log.delete();
    cpu_op(1'b0, 16'h0020, 32'h11, got, st);
    cpu_op(1'b0, 16'h0020, 32'h22, got, st);
    cpu_op(1'b1, 16'h0020, 32'h0, got, st);
    chk("t2_data", got, 32'h22);
    idle(20);
    chk("t2_nwr", txn_log.size(), 2);
    chk("t2_w0", {txn_log[0], wdata_log[0]}, {1'b1, 14'h8, 32'h11});
    chk("t2_w1", {txn_log[1], wdata_log[1]}, {1'b1, 14'h8, 32'h22});
    chk("t2_mem", bmem[14'h8], 32'h22);

    // Five stores into four entries, ack three cycles after the request
    // appears: the fifth waits through the full cycle and the pop cycle.
    mem_lat = 3;
    txn_log.delete();
    wdata_log.delete();
    for (int k = 0; k < 5; k++) begin
      cpu_op(1'b0, 16'(16'h0040 + 4 * k), 32'(32'hA0 + k), got, st);
      chk("t3_stall", st, (k == 4) ? 2 : 0);
    end
    idle(40);
    chk("t3_nwr", txn_log.size(), 5);
    for (int k = 0; k < 5; k++)
      chk("t3_wr", {txn_log[k], wdata_log[k]}, {1'b1, 14'(14'h10 + k), 32'(32'hA0 + k)});

    // Load miss: one cycle to see the miss, request with ack three cycles
    // later, then the response cycle.
    bmem[14'h40]    = 32'hCAFEF00D;
    ref_mem[14'h40] = 32'hCAFEF00D;
    txn_log.delete();
    cpu_op(1'b1, 16'h0100, 32'h0, got, st);
    chk("t4_data", got, 32'hCAFEF00D);
    chk("t4_stall", st, 5);
    chk("t4_nreq", txn_log.size(), 1);
    chk("t4_req", txn_log[0], {1'b0, 14'h40});
    idle(5);

    // Miss while a write is in flight with two more queued.
    mem_lat = 4;
    txn_log.delete();
    cpu_op(1'b0, 16'h0200, 32'h1, got, st);
    cpu_op(1'b0, 16'h0204, 32'h2, got, st);
    cpu_op(1'b0, 16'h0208, 32'h3, got, st);
    cpu_op(1'b1, 16'h0300, 32'h0, got, st);
    idle(40);
    chk("t5_n", txn_log.size(), 4);
    chk("t5_0", txn_log[0], {1'b1, 14'h80});
    chk("t5_1", txn_log[1], {1'b0, 14'hC0});
    chk("t5_2", txn_log[2], {1'b1, 14'h81});
    chk("t5_3", txn_log[3], {1'b1, 14'h82});

    // Reset in the middle of a write with three entries queued.
    bmem[14'h90]    = 32'h0BADF00D;
    ref_mem[14'h90] = 32'h0BADF00D;
    mem_lat = 10;
    cpu_op(1'b0, 16'h0240, 32'h77, got, st);
    cpu_op(1'b0, 16'h0244, 32'h78, got, st);
    cpu_op(1'b0, 16'h0248, 32'h79, got, st);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1 chk("t6_req", {63'd0, mem_req}, 64'd0);
    repeat (2) @(negedge clk);
    @(posedge clk);
    #3 rst_n = 1'b1;
    @(posedge clk);
    #1;
    mem_lat = 1;
    wr0 = wr_cnt;
    idle(5);
    chk("t6_nowr", 64'(wr_cnt - wr0), 64'd0);
    cpu_op(1'b1, 16'h0240, 32'h0, got, st);
    chk("t6_data", got, 32'h0BADF00D);
    chk("t6_miss", {63'd0, (st > 0)}, 64'd1);
    idle(20);
    chk("t6_nowr2", 64'(wr_cnt - wr0), 64'd0);

    // Randomized traffic over a small set of words.
    rand_lat = 1;
    for (int n = 0; n < 300; n++) begin
      if ($urandom_range(0, 2) == 0)
        cpu_op(1'b1, 16'($urandom_range(0, 15) * 4), 32'h0, got, st);
      else
        cpu_op(1'b0, 16'($urandom_range(0, 15) * 4), $urandom, got, st);
      if ($urandom_range(0, 3) == 0) idle(int'($urandom_range(1, 3)));
    end
    idle(60);
    rand_lat = 0;
    chk("drain_empty", pend.size(), 0);
    for (int i = 0; i < 256; i++) chk("final_mem", bmem[i], ref_mem[i]);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/dmem_write_buffer.md
Name: dmem_write_buffer

Overview:
- Data-memory front end placed directly downstream of the CPU memory-access stage.
- Consumes the CPU's DMEM read/write, address and data buses and returns read data to the CPU.
- Stores are posted into a small FIFO and drained to a multi-cycle backing memory over a req/ack handshake.
- Loads are forwarded from the FIFO when they hit; a load that misses is fetched from backing memory while the CPU pipeline is held via `stall`, which drives the CPU `halt` input.

Parameters:
- BUF_DEPTH, 4: number of posted-write entries; power of two, 2..16.
- ADDR_W, 16: byte-address width, matching the DMEM address bus.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- cpu_valid  in  1  memory operation present this cycle; the top level is extended to export this from the memory-stage op code.
- cpu_read_wrn  in  1  1 = load, 0 = store.
- cpu_addr  in  ADDR_W  byte address; bits [ADDR_W-1:2] form the word index.
- cpu_wdata  in  32  store data, already size-adjusted by the CPU.
- cpu_rdata  out  32  load data, valid in any cycle where a load is present and `stall` = 0.
- stall  out  1  hold the CPU pipeline.
- mem_req  out  1  backing request; held high until ack.
- mem_we  out  1  backing write enable.
- mem_addr  out  ADDR_W-2  backing word address.
- mem_wdata  out  32  backing write data.
- mem_rdata  in  32  backing read data, valid with `mem_ack`.
- mem_ack  in  1  one-cycle completion pulse.

Behaviour:
- Reset values: `stall` = 0, `mem_req` = 0, `mem_we` = 0, `mem_addr` = 0, `mem_wdata` = 0, `cpu_rdata` = 0. FIFO empty, FSM in IDLE.
- Reset asserted mid-transaction: all buffered writes are discarded and `mem_req` drops asynchronously.
- FIFO structure: circular buffer with head and tail pointers plus a count of 0..BUF_DEPTH. Each entry holds {word address, data}.
- Store (valid && !read_wrn):
  - Not full: the entry is pushed at the clock edge; `stall` = 0.
  - Full: `stall` = 1 (combinational) until count < BUF_DEPTH.
  - A pop in the same cycle does not release the stall; push happens on the following cycle.
- Load hit (valid && read_wrn, word index matches any valid entry):
  - `cpu_rdata` = data of the youngest matching entry, combinational.
  - `stall` = 0; zero added latency.
  - A load in the same cycle as a push never observes that push.
- Load miss:
  - `stall` = 1 from the first cycle the miss is seen.
  - The backing read is issued with priority over further drains.
  - After `mem_ack`, `mem_rdata` is captured into `rd_hold`.
  - In the RESP cycle, `stall` = 0 and `cpu_rdata` = `rd_hold`.
  - Minimum latency is 2 cycles plus backing delay.
- FSM states and transitions:
  - IDLE:
    - Load miss present: go to RD_WAIT (`mem_req` = 1, `mem_we` = 0).
    - Otherwise, FIFO not empty: go to WR_WAIT with head entry on the bus (`mem_req` = 1, `mem_we` = 1).
    - Otherwise: stay in IDLE.
  - WR_WAIT: hold bus signals stable. On `mem_ack`, pop the head. Then:
    - Load miss present: go to RD_WAIT.
    - Otherwise, FIFO still not empty: issue the next write, staying in WR_WAIT.
    - Otherwise: go to IDLE.
    - A load miss arriving here keeps `stall` = 1 throughout.
  - RD_WAIT: hold the address. On `mem_ack`, latch `rd_hold` and go to RD_RESP.
  - RD_RESP: one cycle with `stall` = 0; the CPU consumes the data. Always return to IDLE without reissuing, even though `cpu_valid` is still high this cycle.
- Handshake rules:
  - `mem_req` deasserts in the cycle after `mem_ack` unless a new request is issued back-to-back.
  - `mem_addr`, `mem_wdata` and `mem_we` change only when a new request starts.
- Ordering: a read that misses is safe to bypass buffered writes because no entry matches its address. Duplicate-address stores occupy separate entries and drain in program order.
- Reads with `cpu_valid` = 0: no backing activity; `cpu_rdata` = 0.
- Pointer wrap: head and tail wrap modulo BUF_DEPTH. Full is count == BUF_DEPTH; empty is count == 0.

Decomposition:
- Shared defines: FSM state encodings (IDLE=2'd0, WR_WAIT=2'd1, RD_WAIT=2'd2, RD_RESP=2'd3), added to the common defines file.
- Sub-module `wbuf_fifo`: entry storage, pointers, count, push/pop and the parallel youngest-match forwarding search (outputs `hit` and `hit_data`).
- FSM and backing-bus logic stay in `dmem_write_buffer`.

Test Plan:
- Store 0xDEADBEEF to addr 0x0010, then load 0x0010 on the next cycle with `mem_ack` held low: `cpu_rdata` = 0xDEADBEEF, `stall` = 0.
- Stores 0x11 then 0x22 to 0x0020, then a load of 0x0020 before drain: returns 0x22. After drain, the backing memory sees both writes in order and ends holding 0x22.
- Five stores with BUF_DEPTH=4 and ack latency 3: `stall` rises on the fifth store and the fifth entry is pushed one cycle after the first pop. There are exactly 5 `mem_we` transactions in order.
- Load miss at 0x0100 with backing value 0xCAFEF00D and ack after 4 cycles: `stall` high for 5 cycles, `cpu_rdata` = 0xCAFEF00D in RESP, exactly one read request.
- Load miss while a write is in flight with 2 entries queued: the in-flight write completes, the read is issued next, and the remaining 2 writes drain afterwards.
- Assert `rst_n` low during WR_WAIT with 3 entries queued: `mem_req` = 0 immediately. After release, the FIFO is empty, a load of any address issues a fresh backing read, and no writes occur.
